// File: rtl/lamp_pkg.sv
// Shared types and default constants for the multi-channel lamp controller.
package lamp_pkg;

    // Global operating mode, encoded exactly as driven on the mode pins.
    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_TIMED  = 2'b01,
        MODE_TOGGLE = 2'b10,
        MODE_ON     = 2'b11
    } mode_e;

    localparam int CW_DEF   = 8;
    localparam int SYNC_DEF = 2;

endpackage

// File: rtl/lamp_chan.sv
// One lamp channel: switch synchronizer, parity change detection, on-timer,
// toggle state and expire pulse. Optional pre-off warning blink is built when
// the macro LAMP_WARN_EN is defined; otherwise the lamp is steady while the
// timer runs.
module lamp_chan
    import lamp_pkg::*;
#(
    parameter int SW       = 3,
    parameter int CW       = CW_DEF,
    parameter int SYNC     = SYNC_DEF,
    parameter int WARN_LEN = 16,
    parameter int WARN_BIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [SW-1:0] sw,
    input  mode_e         mode,
    input  logic          mode_chg,
    input  logic          armed,
    input  logic [CW-1:0] dur,
    output logic          lamp,
    output logic          expire
);

    logic [SYNC-1:0][SW-1:0] sync_q;
    logic                    par;
    logic                    par_prev_q;
    logic                    ev_q;
    logic [CW-1:0]           timer_q;
    logic [CW-1:0]           timer_n;
    logic                    tog_q;
    logic                    tog_n;
    logic                    lamp_n;
    logic                    expire_n;
    logic                    timed_lamp;

    // Parity of the fully synchronized switch levels; any flip of an odd
    // number of switches in one sample changes it.
    assign par = ^sync_q[SYNC-1];

    // Synchronizer chain, previous parity and the registered event strobe.
    // Events seen before arming are discarded so that switch levels present
    // at reset release never light the lamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            par_prev_q <= 1'b0;
            ev_q       <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC-2:0], sw};
            par_prev_q <= par;
            ev_q       <= (par != par_prev_q) & armed;
        end
    end

    // Next timer / toggle state and expire flag for the current mode.
    // A mode change clears everything and drops any event of that cycle.
    // In TIMED mode an event with dur = 0 is ignored; the timer only
    // decrements while nonzero, so it never wraps.
    always_comb begin
        timer_n  = timer_q;
        tog_n    = tog_q;
        expire_n = 1'b0;
        if (mode_chg) begin
            timer_n = '0;
            tog_n   = 1'b0;
        end else begin
            case (mode)
                MODE_TIMED: begin
                    tog_n = 1'b0;
                    if (ev_q && (dur != '0)) begin
                        timer_n = dur;
                    end else if (timer_q != '0) begin
                        timer_n  = timer_q - CW'(1);
                        expire_n = (timer_q == CW'(1));
                    end
                end
                MODE_TOGGLE: begin
                    timer_n = '0;
                    if (ev_q) begin
                        tog_n = ~tog_q;
                    end
                end
                default: begin
                    timer_n = '0;
                    tog_n   = 1'b0;
                end
            endcase
        end
    end

`ifdef LAMP_WARN_EN
    logic in_warn;
    assign in_warn    = (timer_n != '0) && (32'(timer_n) <= WARN_LEN);
    assign timed_lamp = in_warn ? timer_n[WARN_BIT] : (timer_n != '0);
`else
    logic unused_warn_cfg;
    assign unused_warn_cfg = (WARN_LEN > WARN_BIT);
    assign timed_lamp      = (timer_n != '0);
`endif

    // Lamp drive derived from the next state so it is registered together
    // with a timer load or toggle.
    always_comb begin
        case (mode)
            MODE_TIMED:  lamp_n = timed_lamp;
            MODE_TOGGLE: lamp_n = tog_n;
            MODE_ON:     lamp_n = 1'b1;
            default:     lamp_n = 1'b0;
        endcase
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            tog_q   <= 1'b0;
            lamp    <= 1'b0;
            expire  <= 1'b0;
        end else begin
            timer_q <= timer_n;
            tog_q   <= tog_n;
            lamp    <= lamp_n;
            expire  <= expire_n;
        end
    end

endmodule

// File: rtl/lamp_ctrl_multi.sv
// Multi-channel stairwell/corridor lamp controller top. Holds the registered
// mode copy used for mode-change detection, the post-reset arming counter,
// and CH independent lamp_chan instances. Optional feature macro:
// LAMP_WARN_EN (pre-off warning blink in TIMED mode).
module lamp_ctrl_multi
    import lamp_pkg::*;
#(
    parameter int CH       = 4,
    parameter int SW       = 3,
    parameter int CW       = CW_DEF,
    parameter int SYNC     = SYNC_DEF,
    parameter int WARN_LEN = 16,
    parameter int WARN_BIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH*SW-1:0] sw,
    input  logic [1:0]       mode,
    input  logic [CW-1:0]    dur,
    output logic [CH-1:0]    lamp,
    output logic [CH-1:0]    expire,
    output logic             armed
);

    localparam int AW = $clog2(SYNC + 2);

    mode_e         mode_cur;
    mode_e         mode_q;
    logic          mode_chg;
    logic [AW-1:0] arm_cnt_q;

    assign mode_cur = mode_e'(mode);
    assign mode_chg = (mode_cur != mode_q);

    // Registered copy of the mode; a difference marks the mode-change cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_OFF;
        end else begin
            mode_q <= mode_cur;
        end
    end

    // Arming counter: armed rises SYNC+1 cycles after reset release, once
    // the synchronizers hold real switch levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_q <= '0;
            armed     <= 1'b0;
        end else if (!armed) begin
            arm_cnt_q <= arm_cnt_q + AW'(1);
            armed     <= (arm_cnt_q == AW'(SYNC));
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        lamp_chan #(
            .SW       (SW),
            .CW       (CW),
            .SYNC     (SYNC),
            .WARN_LEN (WARN_LEN),
            .WARN_BIT (WARN_BIT)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .sw       (sw[i*SW +: SW]),
            .mode     (mode_cur),
            .mode_chg (mode_chg),
            .armed    (armed),
            .dur      (dur),
            .lamp     (lamp[i]),
            .expire   (expire[i])
        );
    end

endmodule

// File: tb/tb_lamp_ctrl_multi.sv
// Self-checking bench for lamp_ctrl_multi (default build, 4 channels x 3
// switches, 8-bit timer, 2-stage synchronizer). Expected output vectors are
// queued with the cycle they are due and compared by a negedge monitor.
module tb_lamp_ctrl_multi;

    localparam int CH   = 4;
    localparam int SW   = 3;
    localparam int CW   = 8;
    localparam int SYNC = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH*SW-1:0] sw;
    logic [1:0]       mode;
    logic [CW-1:0]    dur;
    logic [CH-1:0]    lamp;
    logic [CH-1:0]    expire;
    logic             armed;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        logic [8:0] val;
        string      tag;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    lamp_ctrl_multi #(
        .CH       (CH),
        .SW       (SW),
        .CW       (CW),
        .SYNC     (SYNC),
        .WARN_LEN (16),
        .WARN_BIT (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sw     (sw),
        .mode   (mode),
        .dur    (dur),
        .lamp   (lamp),
        .expire (expire),
        .armed  (armed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue expected {armed, expire, lamp} for cycles c0..c1 inclusive.
    task automatic expect_rng(input string tag, input int c0, input int c1,
                              input logic [3:0] l, input logic [3:0] x, input logic a);
        for (int c = c0; c <= c1; c++) begin
            sb.push_back('{c, {a, x, l}, tag});
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare every expectation that has come due by this half-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check_eq(mon_e.tag, {23'd0, armed, expire, lamp}, {23'd0, mon_e.val});
        end
    end

    initial begin
        int e, f, g, h, j, k, m, n, q, p, r;

        // Reset with channel 0 switches all high, TIMED, dur 10.
        sw    = 12'b000_000_000_111;
        mode  = 2'b01;
        dur   = 8'd10;
        rst_n = 1'b0;
        step(3);
        check_eq("rst_lamp", 32'(lamp), 32'd0);
        check_eq("rst_expire", 32'(expire), 32'd0);
        check_eq("rst_armed", 32'(armed), 32'd0);
        e = cyc;
        rst_n = 1'b1;
        expect_rng("arm_wait", e, e + 2, 4'b0000, 4'b0000, 1'b0);
        expect_rng("armed", e + 3, e + 10, 4'b0000, 4'b0000, 1'b1);
        step(10);

        // Single flip, dur 5.
        e = cyc;
        dur = 8'd5;
        sw[0] = ~sw[0];
        expect_rng("t1_pre", e + 1, e + 3, 4'b0000, 4'b0000, 1'b1);
        expect_rng("t1_on", e + 4, e + 8, 4'b0001, 4'b0000, 1'b1);
        expect_rng("t1_expire", e + 9, e + 9, 4'b0000, 4'b0001, 1'b1);
        expect_rng("t1_post", e + 10, e + 12, 4'b0000, 4'b0000, 1'b1);
        step(13);

        // Retrigger at timer = 2, dur 8.
        e = cyc;
        dur = 8'd8;
        sw[1] = ~sw[1];
        expect_rng("t2_pre", e + 1, e + 3, 4'b0000, 4'b0000, 1'b1);
        expect_rng("t2_on", e + 4, e + 18, 4'b0001, 4'b0000, 1'b1);
        expect_rng("t2_expire", e + 19, e + 19, 4'b0000, 4'b0001, 1'b1);
        expect_rng("t2_post", e + 20, e + 22, 4'b0000, 4'b0000, 1'b1);
        step(7);
        sw[2] = ~sw[2];
        step(16);

        // Two simultaneous flips on channel 1: no event.
        e = cyc;
        sw[4:3] = ~sw[4:3];
        expect_rng("t3_pair", e + 1, e + 10, 4'b0000, 4'b0000, 1'b1);
        step(8);
        mode = 2'b10;
        step(2);
        // TOGGLE: flip on, flip off.
        f = cyc;
        sw[3] = ~sw[3];
        expect_rng("t3_tog_pre", f + 1, f + 3, 4'b0000, 4'b0000, 1'b1);
        expect_rng("t3_tog_on", f + 4, f + 13, 4'b0010, 4'b0000, 1'b1);
        expect_rng("t3_tog_off", f + 14, f + 16, 4'b0000, 4'b0000, 1'b1);
        step(10);
        sw[3] = ~sw[3];
        step(7);

        // TIMED then OFF mid-countdown at timer = 4.
        g = cyc;
        mode = 2'b01;
        expect_rng("t4_mchg", g + 1, g + 2, 4'b0000, 4'b0000, 1'b1);
        step(2);
        h = cyc;
        sw[6] = ~sw[6];
        expect_rng("t4_pre", h + 1, h + 3, 4'b0000, 4'b0000, 1'b1);
        expect_rng("t4_on", h + 4, h + 8, 4'b0100, 4'b0000, 1'b1);
        expect_rng("t4_off", h + 9, h + 14, 4'b0000, 4'b0000, 1'b1);
        step(8);
        mode = 2'b00;
        step(7);

        // ON: all lamps lit regardless of switches.
        j = cyc;
        mode = 2'b11;
        expect_rng("t5_on", j + 1, j + 8, 4'b1111, 4'b0000, 1'b1);
        expect_rng("t5_off", j + 9, j + 10, 4'b0000, 4'b0000, 1'b1);
        step(2);
        sw[9] = ~sw[9];
        step(6);
        mode = 2'b00;
        step(3);

        // TIMED: three flips on channel 3 plus single flips on 0 and 1.
        k = cyc;
        mode = 2'b01;
        expect_rng("t6_mchg", k + 1, k + 2, 4'b0000, 4'b0000, 1'b1);
        step(2);
        m = cyc;
        dur = 8'd3;
        sw[11:9] = ~sw[11:9];
        sw[0] = ~sw[0];
        sw[3] = ~sw[3];
        expect_rng("t6_pre", m + 1, m + 3, 4'b0000, 4'b0000, 1'b1);
        expect_rng("t6_on", m + 4, m + 6, 4'b1011, 4'b0000, 1'b1);
        expect_rng("t6_expire", m + 7, m + 7, 4'b0000, 4'b1011, 1'b1);
        expect_rng("t6_post", m + 8, m + 9, 4'b0000, 4'b0000, 1'b1);
        step(10);

        // dur = 0: event has no visible effect.
        n = cyc;
        dur = 8'd0;
        sw[7] = ~sw[7];
        expect_rng("t7_dur0", n + 1, n + 8, 4'b0000, 4'b0000, 1'b1);
        step(9);

        // dur = 255: full-range countdown, no wrap.
        q = cyc;
        dur = 8'hFF;
        sw[8] = ~sw[8];
        expect_rng("t8_pre", q + 1, q + 3, 4'b0000, 4'b0000, 1'b1);
        expect_rng("t8_on", q + 4, q + 258, 4'b0100, 4'b0000, 1'b1);
        expect_rng("t8_expire", q + 259, q + 259, 4'b0000, 4'b0100, 1'b1);
        expect_rng("t8_post", q + 260, q + 261, 4'b0000, 4'b0000, 1'b1);
        step(262);

        // Asynchronous reset mid-countdown, then re-arming.
        p = cyc;
        dur = 8'd20;
        sw[0] = ~sw[0];
        expect_rng("t9_pre", p + 1, p + 3, 4'b0000, 4'b0000, 1'b1);
        expect_rng("t9_on", p + 4, p + 7, 4'b0001, 4'b0000, 1'b1);
        step(8);
        rst_n = 1'b0;
        #1;
        check_eq("t9_async_rst", {23'd0, armed, expire, lamp}, 32'd0);
        step(2);
        r = cyc;
        rst_n = 1'b1;
        expect_rng("t9_rearm_wait", r, r + 2, 4'b0000, 4'b0000, 1'b0);
        expect_rng("t9_rearm", r + 3, r + 6, 4'b0000, 4'b0000, 1'b1);
        step(7);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            step(1);
        end
        check_eq("sb_drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
